// File: rtl/alarm_pkg.sv
// Shared constants for the alarm path: state encoding, state width and the
// default delay values used by both the detector top level and this controller.
package alarm_pkg;

    localparam int unsigned STATE_W = 3;

    // State encoding; codes 5..7 are illegal and recover to ST_DISARMED.
    localparam logic [STATE_W-1:0] ST_DISARMED    = 3'd0;
    localparam logic [STATE_W-1:0] ST_EXIT_DELAY  = 3'd1;
    localparam logic [STATE_W-1:0] ST_ARMED       = 3'd2;
    localparam logic [STATE_W-1:0] ST_ENTRY_DELAY = 3'd3;
    localparam logic [STATE_W-1:0] ST_ALARM       = 3'd4;

    // Default timing and keypad settings.
    localparam int unsigned DEF_EXIT_DELAY_CYC  = 16;
    localparam int unsigned DEF_ENTRY_DELAY_CYC = 8;
    localparam int unsigned DEF_SIREN_CYC       = 32;
    localparam int unsigned DEF_CNT_W           = 8;
    localparam int unsigned DEF_CODE_W          = 4;
    localparam int unsigned DEF_MAX_TRIES       = 3;

endpackage : alarm_pkg

// File: rtl/alarm_delay_timer.sv
// Loadable down-counter for the arming/entry/siren delays.
// Ports: clk, rst (sync, active-high), load/load_val (load wins over
// decrement), done (count is zero; the counter holds at zero, never wraps).
module alarm_delay_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Count register: load, else decrement until zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule : alarm_delay_timer

// File: rtl/alarm_siren_controller.sv
// Arming/disarming FSM downstream of the opening-count detector: exit delay,
// entry delay, time-limited siren bursts, keypad disarm and tamper escalation.
// Ports: clk, rst (sync, active-high), arm_req, trigger (level), code_valid,
// code_in -> siren, armed_led, beep, state_o (all decoded from registers).
module alarm_siren_controller
    import alarm_pkg::*;
#(
    parameter int unsigned          EXIT_DELAY_CYC  = DEF_EXIT_DELAY_CYC,
    parameter int unsigned          ENTRY_DELAY_CYC = DEF_ENTRY_DELAY_CYC,
    parameter int unsigned          SIREN_CYC       = DEF_SIREN_CYC,
    parameter int unsigned          CNT_W           = DEF_CNT_W,
    parameter int unsigned          CODE_W          = DEF_CODE_W,
    parameter logic [CODE_W-1:0]    DISARM_CODE     = 4'hA,
    parameter int unsigned          MAX_TRIES       = DEF_MAX_TRIES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm_req,
    input  logic               trigger,
    input  logic               code_valid,
    input  logic [CODE_W-1:0]  code_in,
    output logic               siren,
    output logic               armed_led,
    output logic               beep,
    output logic [STATE_W-1:0] state_o
);

    localparam int unsigned TRY_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_CYC - 1);
    localparam logic [TRY_W-1:0] LAST_TRY   = TRY_W'(MAX_TRIES - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [TRY_W-1:0]   tries;
    logic [TRY_W-1:0]   tries_nxt;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_load_val;
    logic               tmr_done;
    logic               good;
    logic               bad;

    assign good = code_valid && (code_in == DISARM_CODE);
    assign bad  = code_valid && (code_in != DISARM_CODE);

    alarm_delay_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // Next-state, wrong-code count and timer control.
    // Priority: good code > tamper > timer expiry / trigger.
    always_comb begin
        state_nxt    = state;
        tries_nxt    = tries;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state)
            ST_DISARMED: begin
                tries_nxt = '0;
                if (arm_req) begin
                    state_nxt    = ST_EXIT_DELAY;
                    tmr_load     = 1'b1;
                    tmr_load_val = EXIT_LOAD;
                end
            end

            ST_EXIT_DELAY, ST_ARMED, ST_ENTRY_DELAY, ST_ALARM: begin
                if (good) begin
                    // Clearing the timer keeps DISARMED at count zero.
                    state_nxt    = ST_DISARMED;
                    tries_nxt    = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = '0;
                end else if (bad && (tries >= LAST_TRY)) begin
                    // Tamper: escalate (or restart the burst if already in ALARM).
                    state_nxt    = ST_ALARM;
                    tries_nxt    = '0;
                    tmr_load     = 1'b1;
                    tmr_load_val = SIREN_LOAD;
                end else begin
                    if (bad) begin
                        tries_nxt = tries + TRY_W'(1);
                    end
                    case (state)
                        ST_EXIT_DELAY: begin
                            if (tmr_done) begin
                                state_nxt = ST_ARMED;
                            end
                        end
                        ST_ARMED: begin
                            if (trigger) begin
                                state_nxt    = ST_ENTRY_DELAY;
                                tmr_load     = 1'b1;
                                tmr_load_val = ENTRY_LOAD;
                            end
                        end
                        ST_ENTRY_DELAY: begin
                            if (tmr_done) begin
                                state_nxt    = ST_ALARM;
                                tmr_load     = 1'b1;
                                tmr_load_val = SIREN_LOAD;
                            end
                        end
                        ST_ALARM: begin
                            if (tmr_done) begin
                                if (trigger) begin
                                    tmr_load     = 1'b1;
                                    tmr_load_val = SIREN_LOAD;
                                end else begin
                                    state_nxt = ST_ARMED;
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            default: begin
                state_nxt    = ST_DISARMED;
                tries_nxt    = '0;
                tmr_load     = 1'b1;
                tmr_load_val = '0;
            end
        endcase
    end

    // State register with outputs registered from the next-state decode,
    // so they always equal the decode of the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_DISARMED;
            tries     <= '0;
            siren     <= 1'b0;
            armed_led <= 1'b0;
            beep      <= 1'b0;
        end else begin
            state     <= state_nxt;
            tries     <= tries_nxt;
            siren     <= (state_nxt == ST_ALARM);
            armed_led <= (state_nxt == ST_ARMED) || (state_nxt == ST_ENTRY_DELAY) ||
                         (state_nxt == ST_ALARM);
            beep      <= (state_nxt == ST_EXIT_DELAY) || (state_nxt == ST_ENTRY_DELAY);
        end
    end

    assign state_o = state;

endmodule : alarm_siren_controller
